// File: rtl/vpu_req_arbiter.sv
// Round-robin arbiter sharing one registered VPU request slot among NUM_REQ requesters, tagging each issue with its source ID.
// Optional per-requester saturating grant counters are built when VPU_ARB_STAT_EN is defined.
module vpu_req_arbiter #(
  parameter int unsigned NUM_REQ             = 4,
  parameter type         vpu_h2d_req_instr_t = logic [31:0],
  parameter int unsigned INSTR_W             = $bits(vpu_h2d_req_instr_t),
  parameter int unsigned ID_W                = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*INSTR_W-1:0] i_req_instr,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_vpu_valid,
  output logic [INSTR_W-1:0]         o_vpu_instr,
  output logic [ID_W-1:0]            o_vpu_src_id,
  input  logic                       i_vpu_ready,
  input  logic [ID_W-1:0]            i_stat_sel,
  output logic [15:0]                o_stat_cnt
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_src_id;
  logic [INSTR_W-1:0] r_instr;
  logic [ID_W-1:0]    w_win;
  logic               w_found;
  logic               w_load;
  int unsigned        w_win_lsb;

  // (base + off) mod NUM_REQ, both operands already below NUM_REQ
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  // First valid requester at or after the round-robin pointer
  always_comb begin
    w_found = 1'b0;
    w_win   = r_rr_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req_valid[wrap_add(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = wrap_add(r_rr_ptr, k);
      end
    end
  end

  // No grant while reset is held: the slot is about to be cleared and the grant would be lost
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    o_req_ready = '0;
    if (rst_n) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_found) begin
            w_load      = 1'b1;
            w_state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          if (i_vpu_ready) begin
            w_load      = w_found;
            w_state_nxt = w_found ? ST_FULL : ST_EMPTY;
          end
        end
      endcase
    end
    if (w_load) o_req_ready[w_win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  assign w_win_lsb = 32'(w_win) * INSTR_W;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr  <= '0;
      r_src_id <= '0;
      r_rr_ptr <= '0;
    end else if (w_load) begin
      r_instr  <= i_req_instr[w_win_lsb +: INSTR_W];
      r_src_id <= w_win;
      r_rr_ptr <= wrap_add(w_win, 1);
    end
  end

  assign o_vpu_valid  = (r_state == ST_FULL);
  assign o_vpu_instr  = r_instr;
  assign o_vpu_src_id = r_src_id;

`ifdef VPU_ARB_STAT_EN
  logic [15:0] r_grant_cnt [NUM_REQ];

  // Saturating grant counters, one per requester
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
    end else if (w_load && (r_grant_cnt[w_win] != 16'hFFFF)) begin
      r_grant_cnt[w_win] <= r_grant_cnt[w_win] + 16'd1;
    end
  end

  always_comb begin
    o_stat_cnt = '0;
    if (32'(i_stat_sel) < NUM_REQ) o_stat_cnt = r_grant_cnt[i_stat_sel];
  end
`else
  logic w_stat_sel_unused;

  assign w_stat_sel_unused = ^i_stat_sel;
  assign o_stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_vpu_req_arbiter.sv
// Self-checking bench for vpu_req_arbiter: directed pinning checks plus randomized traffic against a behavioural model.
module tb_vpu_req_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned IW  = 32;
  localparam int unsigned IDW = 2;

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*IW-1:0] req_instr = '0;
  logic [N-1:0]    req_ready;
  logic            vpu_valid;
  logic [IW-1:0]   vpu_instr;
  logic [IDW-1:0]  vpu_src_id;
  logic            vpu_ready = 1'b0;
  logic [IDW-1:0]  stat_sel  = '0;
  logic [15:0]     stat_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vpu_req_arbiter #(.NUM_REQ(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (req_valid),
    .i_req_instr  (req_instr),
    .o_req_ready  (req_ready),
    .o_vpu_valid  (vpu_valid),
    .o_vpu_instr  (vpu_instr),
    .o_vpu_src_id (vpu_src_id),
    .i_vpu_ready  (vpu_ready),
    .i_stat_sel   (stat_sel),
    .o_stat_cnt   (stat_cnt)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: slot contents, round-robin start point, grant totals
  bit            m_known = 1'b0;
  bit            m_full;
  logic [IW-1:0] m_instr;
  int            m_src;
  int            m_ptr;
  int            m_cnt [N];
  logic [N-1:0]  m_granted = '0;

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    w = pick();
    if (rst_n && (!m_full || vpu_ready) && w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  function automatic logic [15:0] exp_stat();
`ifdef VPU_ARB_STAT_EN
    if (int'(stat_sel) < N) return 16'(m_cnt[stat_sel]);
    return 16'h0;
`else
    return 16'h0;
`endif
  endfunction

  always @(posedge clk) begin
    int w;
    w = pick();
    m_granted = '0;
    if (!rst_n) begin
      m_known = 1'b1;
      m_full  = 1'b0;
      m_instr = '0;
      m_src   = 0;
      m_ptr   = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (m_known) begin
      if ((!m_full || vpu_ready) && w >= 0) begin
        m_granted[w] = 1'b1;
        m_full       = 1'b1;
        m_instr      = req_instr[w*IW +: IW];
        m_src        = w;
        m_ptr        = (w + 1) % N;
        if (m_cnt[w] < 65535) m_cnt[w]++;
      end else if (m_full && vpu_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Per-cycle comparison of every output against the model, just before the active edge
  initial forever begin
    @(negedge clk);
    #4;
    if (m_known) begin
      check("req_ready",  64'(req_ready),      64'(exp_ready()));
      check("vpu_valid",  64'(vpu_valid),      64'(m_full));
      check("vpu_instr",  64'(vpu_instr),      64'(m_instr));
      check("vpu_src_id", 64'(vpu_src_id),     64'(m_src));
      check("rr_ptr",     64'(dut.r_rr_ptr),   64'(m_ptr));
      check("stat_cnt",   64'(stat_cnt),       64'(exp_stat()));
    end
  end

  task automatic drive(input logic r, input logic [N-1:0] v, input logic vr);
    @(negedge clk);
    rst_n     = r;
    req_valid = v;
    vpu_ready = vr;
    #4;
  endtask

  int exp_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    for (int i = 0; i < N; i++) req_instr[i*IW +: IW] = 32'hA000_0000 + 32'(i);

    // single requester after reset
    drive(1'b0, 4'b0000, 1'b0);
    check("reset_valid", 64'(vpu_valid), 64'd0);
    check("reset_instr", 64'(vpu_instr), 64'd0);
    drive(1'b1, 4'b0100, 1'b1);
    check("t1_ready", 64'(req_ready), 64'b0100);
    drive(1'b1, 4'b0000, 1'b0);
    check("t1_valid", 64'(vpu_valid), 64'd1);
    check("t1_src", 64'(vpu_src_id), 64'd2);
    check("t1_instr", 64'(vpu_instr), 64'hA000_0002);
    check("t1_ptr", 64'(dut.r_rr_ptr), 64'd3);

    // full rotation, back-to-back
    drive(1'b0, 4'b0000, 1'b0);
    drive(1'b1, 4'b1111, 1'b1);
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 4'b1111, 1'b1);
      check("rot_valid", 64'(vpu_valid), 64'd1);
      check("rot_src", 64'(vpu_src_id), 64'(exp_seq[c]));
    end

    // hold while decoder stalls, then reload on the accept pulse
    drive(1'b0, 4'b0000, 1'b0);
    req_instr[1*IW +: IW] = 32'h1111_1111;
    req_instr[2*IW +: IW] = 32'h2222_2222;
    drive(1'b1, 4'b0010, 1'b0);
    check("hold_grant", 64'(req_ready), 64'b0010);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_instr[1*IW +: IW] = $urandom();
      req_valid = 4'b0110;
      vpu_ready = 1'b0;
      #4;
      check("hold_instr", 64'(vpu_instr), 64'h1111_1111);
      check("hold_src", 64'(vpu_src_id), 64'd1);
      check("hold_ready", 64'(req_ready), 64'd0);
    end
    drive(1'b1, 4'b0110, 1'b1);
    check("pulse_ready", 64'(req_ready), 64'b0100);
    drive(1'b1, 4'b0010, 1'b0);
    check("pulse_src", 64'(vpu_src_id), 64'd2);
    check("pulse_instr", 64'(vpu_instr), 64'h2222_2222);

    // drain to empty; accept while empty is ignored
    drive(1'b1, 4'b0000, 1'b1);
    drive(1'b1, 4'b0000, 1'b0);
    check("drain_valid", 64'(vpu_valid), 64'd0);
    drive(1'b1, 4'b0000, 1'b1);
    drive(1'b1, 4'b0000, 1'b0);
    check("empty_valid", 64'(vpu_valid), 64'd0);
    check("empty_ptr", 64'(dut.r_rr_ptr), 64'd3);

    // reset while full with requester 3 pending
    drive(1'b1, 4'b0001, 1'b0);
    drive(1'b1, 4'b1000, 1'b0);
    check("pre_rst_valid", 64'(vpu_valid), 64'd1);
    drive(1'b0, 4'b1000, 1'b0);
    drive(1'b0, 4'b1000, 1'b0);
    check("rst_valid", 64'(vpu_valid), 64'd0);
    check("rst_ptr", 64'(dut.r_rr_ptr), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    drive(1'b1, 4'b1000, 1'b0);
    check("post_rst_ready", 64'(req_ready), 64'b1000);
    drive(1'b1, 4'b0000, 1'b0);
    check("post_rst_src", 64'(vpu_src_id), 64'd3);

`ifdef VPU_ARB_STAT_EN
    drive(1'b0, 4'b0000, 1'b0);
    stat_sel = 2'd0;
    for (int c = 0; c < 70000; c++) drive(1'b1, 4'b0001, 1'b1);
    drive(1'b1, 4'b0000, 1'b0);
    check("stat_sat", 64'(stat_cnt), 64'hFFFF);
    stat_sel = 2'd1;
    #0;
    check("stat_other", 64'(stat_cnt), 64'd0);
`else
    stat_sel = 2'd1;
    drive(1'b1, 4'b0000, 1'b0);
    check("stat_off", 64'(stat_cnt), 64'd0);
`endif

    // randomized traffic honouring the hold-until-ready rule
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !m_granted[i]) begin
          if ($urandom_range(9) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = ($urandom_range(9) < 4);
          if (req_valid[i]) req_instr[i*IW +: IW] = $urandom();
        end
      end
      if (c < 300) req_valid = 4'b1111;
      vpu_ready = (c < 300) ? 1'b1 : 1'($urandom_range(1));
      rst_n     = ($urandom_range(199) != 0);
      stat_sel  = IDW'($urandom_range(N - 1));
    end

    drive(1'b1, 4'b0000, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
